// File: rtl/bcd_countdown_bank.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_bank
// Purpose  : NUM_CH HH:MM:SS BCD countdown timers sharing one 1 s tick.
// Revision : 1.0
// ============================================================================
module bcd_countdown_bank #(
  parameter int         CLK_HZ = 50000000,
  parameter int         NUM_CH = 4,
  parameter int         CH_W   = 2,
  parameter logic [3:0] BLANK  = 4'hB
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [2:0]        cmd_op,
  input  logic [23:0]       cmd_data,
  input  logic [CH_W-1:0]   sel_ch,
  output logic [3:0]        d5,
  output logic [3:0]        d4,
  output logic [3:0]        d3,
  output logic [3:0]        d2,
  output logic [3:0]        d1,
  output logic [3:0]        d0,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] expire_pulse,
  output logic              cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int         c_PW       = $clog2(CLK_HZ);
  localparam logic [2:0] c_OP_NOP   = 3'd0;
  localparam logic [2:0] c_OP_LOAD  = 3'd1;
  localparam logic [2:0] c_OP_START = 3'd2;
  localparam logic [2:0] c_OP_PAUSE = 3'd3;
  localparam logic [2:0] c_OP_CLEAR = 3'd4;
  localparam logic [2:0] c_OP_ACK   = 3'd5;
  localparam logic [2:0] c_OP_AUTO  = 3'd6;
  localparam logic [2:0] c_OP_BAD   = 3'd7;
  localparam logic [23:0] c_ONE_SEC = 24'h000001;

  function automatic logic [23:0] f_dec(input logic [23:0] v);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = v;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          if (m1 != 4'd0) m1 = m1 - 4'd1;
          else begin
            m1 = 4'd5;
            if (h0 != 4'd0) h0 = h0 - 4'd1;
            else begin
              h0 = 4'd9;
              h1 = h1 - 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  logic [c_PW-1:0] r_presc;
  logic            r_flash;
  logic            w_tick;

  assign w_tick = (r_presc == c_PW'(CLK_HZ - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_flash <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick || (r_presc == c_PW'(CLK_HZ / 2 - 1))) r_flash <= ~r_flash;
    end
  end

  logic w_load_ok, w_ch_ok, w_glob_rej;

  // Hours are checked as a two-digit BCD value 00..23.
  assign w_load_ok = (cmd_data[23:20] <= 4'd2) && (cmd_data[19:16] <= 4'd9) &&
                     !((cmd_data[23:20] == 4'd2) && (cmd_data[19:16] > 4'd3)) &&
                     (cmd_data[15:12] <= 4'd5) && (cmd_data[11:8] <= 4'd9) &&
                     (cmd_data[7:4]   <= 4'd5) && (cmd_data[3:0]  <= 4'd9);
  assign w_ch_ok    = (int'(cmd_ch) < NUM_CH);
  assign w_glob_rej = cmd_valid && (cmd_op != c_OP_NOP) &&
                      ((cmd_op == c_OP_BAD) || !w_ch_ok);

  logic [NUM_CH-1:0] w_rej, w_run, w_done;
  logic [23:0]       w_value [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t      r_state;
    logic [23:0] r_value, r_preset;
    logic        r_auto, r_expired, r_pulse;
    logic        w_sel, w_acc;

    assign w_sel    = cmd_valid && (cmd_op != c_OP_NOP) && (cmd_op != c_OP_BAD) &&
                      (cmd_ch == CH_W'(i));
    assign w_rej[i] = w_sel &&
                      (((cmd_op == c_OP_LOAD) && ((r_state == S_RUN) || !w_load_ok)) ||
                       ((cmd_op == c_OP_START) && ((r_state == S_DONE) ||
                        ((r_state != S_RUN) && (r_value == 24'd0)))));
    assign w_acc    = w_sel && !w_rej[i];

    // An accepted command takes precedence over the tick for this channel.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state   <= S_IDLE;
        r_value   <= '0;
        r_preset  <= '0;
        r_auto    <= 1'b0;
        r_expired <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (w_acc) begin
          case (cmd_op)
            c_OP_LOAD: begin
              r_preset  <= cmd_data;
              r_value   <= cmd_data;
              r_state   <= S_IDLE;
              r_expired <= 1'b0;
            end
            c_OP_START: r_state <= S_RUN;
            c_OP_PAUSE: if (r_state == S_RUN) r_state <= S_PAUSE;
            c_OP_CLEAR: begin
              r_state   <= S_IDLE;
              r_value   <= r_preset;
              r_expired <= 1'b0;
            end
            c_OP_ACK: begin
              r_expired <= 1'b0;
              if (r_state == S_DONE) begin
                r_state <= S_IDLE;
                r_value <= r_preset;
              end
            end
            c_OP_AUTO: r_auto <= cmd_data[0];
            default: ;
          endcase
        end else if (w_tick && (r_state == S_RUN)) begin
          if (r_value == c_ONE_SEC) begin
            r_expired <= 1'b1;
            r_pulse   <= 1'b1;
            if (r_auto && (r_preset != 24'd0)) begin
              r_value <= r_preset;
            end else begin
              r_value <= '0;
              r_state <= S_DONE;
            end
          end else begin
            r_value <= f_dec(r_value);
          end
        end
      end
    end

    assign w_value[i]      = r_value;
    assign w_run[i]        = (r_state == S_RUN);
    assign w_done[i]       = (r_state == S_DONE);
    assign expired[i]      = r_expired;
    assign expire_pulse[i] = r_pulse;
  end

  assign running = w_run;

  logic [23:0] w_disp, r_disp;
  logic        r_err;

  always_comb begin
    w_disp = {6{BLANK}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch == CH_W'(k)) w_disp = (w_done[k] && r_flash) ? {6{BLANK}} : w_value[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_disp <= '0;
      r_err  <= 1'b0;
    end else begin
      r_disp <= w_disp;
      r_err  <= w_glob_rej || (|w_rej);
    end
  end

  assign {d5, d4, d3, d2, d1, d0} = r_disp;
  assign cmd_err = r_err;

endmodule
`default_nettype wire

// File: doc/bcd_countdown_bank.md
Name: bcd_countdown_bank

Overview:
- Bank of NUM_CH independent HH:MM:SS countdown timers in BCD, all driven by one shared 1 s prescaler.
- Each channel has a preset register, a run/pause/done state machine, optional auto-reload, and a sticky expiry flag.
- A registered display port shows one selected channel on six BCD digit outputs; an expired channel blinks at 1 Hz using blank code BLANK.
- Sits between the key/command decoder and the seven-segment digit drivers. It is the multi-channel, configurable successor to the single-alarm countdown.

Parameters:
- CLK_HZ, 50000000, clock cycles per 1 s tick (even, >=4).
- NUM_CH, 4, number of countdown channels (1..16).
- CH_W, 2, channel index width (>= clog2(NUM_CH), >=1).
- BLANK, 4'hB, digit code that drives a dark digit.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe; one command per cycle, always accepted.
- cmd_ch  in  CH_W  target channel.
- cmd_op  in  3  0 NOP, 1 LOAD, 2 START, 3 PAUSE, 4 CLEAR, 5 ACK, 6 AUTO.
- cmd_data  in  24  LOAD: {h1,h0,m1,m0,s1,s0} BCD; AUTO: bit0 = auto-reload enable.
- sel_ch  in  CH_W  channel shown on display.
- d5,d4,d3,d2,d1,d0  out  4 each  registered digits, d5 = hours tens … d0 = seconds units.
- running  out  NUM_CH  per-channel RUN state.
- expired  out  NUM_CH  sticky per-channel expiry flag.
- expire_pulse  out  NUM_CH  one-cycle pulse on each expiry.
- cmd_err  out  1  one-cycle pulse, registered, when a command is rejected.

Behaviour:
- Reset (async, reset=0): prescaler=0, flash phase=0, all values and presets=00:00:00, all states IDLE, auto=0. All outputs 0; d5..d0=0.
- Prescaler counts 0..CLK_HZ-1 and wraps. tick=1 for one cycle when count==CLK_HZ-1. Flash phase toggles when count==CLK_HZ/2-1 and when count==CLK_HZ-1.
- Per-channel states: IDLE, RUN, PAUSE, DONE.
- LOAD: accepted in IDLE/PAUSE/DONE. Writes preset and value, goes to IDLE, clears expired. Rejected in RUN.
- LOAD validity: h1h0<=23, m1<=5, m0<=9, s1<=5, s0<=9. Any invalid digit -> rejected, nothing changes.
- START: IDLE/PAUSE -> RUN if value!=0. If value==0 -> rejected. In RUN: no-op. In DONE: rejected.
- PAUSE: RUN -> PAUSE; no-op in other states.
- CLEAR: any state -> IDLE, value=preset, expired=0.
- ACK: clears expired; DONE -> IDLE with value=preset; no other state change.
- AUTO: sets auto[cmd_ch]=cmd_data[0] in any state.
- cmd_ch >= NUM_CH or op=7 -> rejected.
- Every rejection pulses cmd_err the next cycle with no state change. NOP never errors.
- Decrement: on tick, every RUN channel decrements by 1 s with BCD borrow.
  - s0 0->9 with borrow into s1; s1 0->5 with borrow into m0; m0 0->9 with borrow into m1; m1 0->5 with borrow into hours.
  - Hours decrement as 2-digit BCD: 10 -> 09, 20 -> 19.
- Expiry: when a tick decrements 00:00:01 to 00:00:00:
  - expired=1 and expire_pulse=1 on the same edge.
  - auto=0: state -> DONE, value holds 00:00:00.
  - auto=1: value=preset and the channel stays RUN. If preset==0, it goes to DONE instead.
- Priority: a valid command to a channel on a tick cycle wins, and that channel skips the tick decrement. Other channels decrement normally.
- Display latency: 1 cycle. d* <= digits of value[sel_ch]. If that channel is DONE and flash phase=1, all six digits = BLANK. sel_ch >= NUM_CH -> all BLANK.
- running/expired are registered state outputs, valid the cycle after the causing edge.
- A reset mid-count abandons all timing; no pulse is emitted.

Test Plan:
- CLK_HZ=10. LOAD ch0 00:00:03, START -> running[0]=1. After 30 cycles: expire_pulse[0] for one cycle, expired[0]=1, running[0]=0, display (sel_ch=0) alternates 000000 and BBBBBB every 5 cycles.
- LOAD ch1 01:00:00, START, one tick -> ch1 value 00:59:59. LOAD 10:00:00, one tick -> 09:59:59.
- LOAD ch2 00:00:02, AUTO=1, START -> expire_pulse[2] every 20 cycles, value reloads to 00:00:02, running[2] stays 1. ACK clears expired[2] only.
- LOAD 00:60:00 -> cmd_err pulse, value unchanged. LOAD 24:00:00 -> cmd_err. START on a zero value -> cmd_err. LOAD while RUN -> cmd_err.
- PAUSE issued on the tick cycle -> value not decremented and state PAUSE. START resumes from that value. Same-cycle tick on another channel still decrements it.
- Assert reset mid-count on 3 running channels -> all outputs 0 immediately, no expire_pulse. After release, all channels are IDLE.
